// File: rtl/int_arbiter.sv
// Interrupt arbiter between SoC interrupt lines and the tinyriscv core.
// Synchronises sources, latches level/edge events, and arbitrates by priority over threshold.
module int_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3,
  parameter int ID_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] int_i,
  input  logic [5:0]         reg_addr_i,
  input  logic [31:0]        reg_data_i,
  input  logic               reg_we_i,
  output logic [31:0]        reg_data_o,
  input  logic               hold_flag_i,
  output logic               int_req_o,
  output logic [ID_W-1:0]    int_id_o,
  input  logic               int_ack_i,
  input  logic               int_done_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [NUM_SRC-1:0] sync1, sync2, sync_d, rise;
  logic [NUM_SRC-1:0] enable, mode, pending;
  logic [PRIO_W-1:0]  threshold;
  logic [PRIO_W-1:0]  prio [NUM_SRC];

  logic [NUM_SRC-1:0] clr, eligible;
  logic [PRIO_W-1:0]  best_prio;
  logic [ID_W-1:0]    best_id;
  logic               any_eligible;
  logic               we_enable, we_pending, we_mode, we_threshold;
  logic               unused_data;

  assign we_enable    = reg_we_i && (reg_addr_i == 6'd0);
  assign we_pending   = reg_we_i && (reg_addr_i == 6'd1);
  assign we_mode      = reg_we_i && (reg_addr_i == 6'd2);
  assign we_threshold = reg_we_i && (reg_addr_i == 6'd3);
  assign unused_data  = ^reg_data_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= '0;
      sync2  <= '0;
      sync_d <= '0;
    end else begin
      sync1  <= int_i;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign rise = sync2 & ~sync_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable    <= '0;
      mode      <= '0;
      threshold <= '0;
      for (int i = 0; i < NUM_SRC; i++) prio[i] <= '0;
    end else begin
      if (we_enable)    enable    <= reg_data_i[NUM_SRC-1:0];
      if (we_mode)      mode      <= reg_data_i[NUM_SRC-1:0];
      if (we_threshold) threshold <= reg_data_i[PRIO_W-1:0];
      for (int i = 0; i < NUM_SRC; i++) begin
        if (reg_we_i && (reg_addr_i == 6'(i + 4))) prio[i] <= reg_data_i[PRIO_W-1:0];
      end
    end
  end

  // Edge sources clear on W1C or on ack of the in-service id
  always_comb begin
    clr = we_pending ? reg_data_i[NUM_SRC-1:0] : '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (state == REQ && int_ack_i && int_id_o == ID_W'(i)) clr[i] = 1'b1;
    end
  end

  // A rising edge outranks a clear landing in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!mode[i])     pending[i] <= sync2[i];
        else if (rise[i]) pending[i] <= 1'b1;
        else if (clr[i])  pending[i] <= 1'b0;
      end
    end
  end

  // Strict compare in ascending order keeps the lowest index on a priority tie
  always_comb begin
    best_prio = '0;
    best_id   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = enable[i] && pending[i] && (prio[i] > threshold);
      if (eligible[i] && (prio[i] > best_prio)) begin
        best_prio = prio[i];
        best_id   = ID_W'(i);
      end
    end
    any_eligible = |eligible;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      int_id_o <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && any_eligible && !hold_flag_i) int_id_o <= best_id;
    end
  end

  always_comb begin
    state_next = state;
    int_req_o  = 1'b0;
    case (state)
      IDLE:    if (any_eligible && !hold_flag_i) state_next = REQ;
      REQ: begin
        int_req_o = 1'b1;
        if (int_ack_i) state_next = ACTIVE;
      end
      ACTIVE:  if (int_done_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    reg_data_o = '0;
    case (reg_addr_i)
      6'd0:    reg_data_o[NUM_SRC-1:0] = enable;
      6'd1:    reg_data_o[NUM_SRC-1:0] = pending;
      6'd2:    reg_data_o[NUM_SRC-1:0] = mode;
      6'd3:    reg_data_o[PRIO_W-1:0]  = threshold;
      6'd36:   reg_data_o[ID_W+1:0]    = {int_id_o, state};
      default: reg_data_o = '0;
    endcase
    for (int i = 0; i < NUM_SRC; i++) begin
      if (reg_addr_i == 6'(i + 4)) reg_data_o[PRIO_W-1:0] = prio[i];
    end
  end

endmodule

// File: tb/tb_int_arbiter.sv
// Directed self-checking bench for int_arbiter: reset, arbitration, threshold, edge mode,
// hold gating, set/clear collision and asynchronous reset mid-handshake.
module tb_int_arbiter;

  logic        clk;
  logic        rst;
  logic [7:0]  int_i;
  logic [5:0]  reg_addr_i;
  logic [31:0] reg_data_i;
  logic        reg_we_i;
  logic [31:0] reg_data_o;
  logic        hold_flag_i;
  logic        int_req_o;
  logic [4:0]  int_id_o;
  logic        int_ack_i;
  logic        int_done_i;

  int total_cnt = 0;
  int fail_cnt  = 0;

  int_arbiter #(.NUM_SRC(8), .PRIO_W(3), .ID_W(5)) dut (
    .clk(clk), .rst(rst), .int_i(int_i),
    .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i), .reg_we_i(reg_we_i),
    .reg_data_o(reg_data_o), .hold_flag_i(hold_flag_i),
    .int_req_o(int_req_o), .int_id_o(int_id_o),
    .int_ack_i(int_ack_i), .int_done_i(int_done_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] addr, input logic [31:0] data);
    reg_addr_i = addr;
    reg_data_i = data;
    reg_we_i   = 1'b1;
    step();
    reg_we_i   = 1'b0;
  endtask

  task automatic checkReg(input string tag, input logic [5:0] addr, input logic [31:0] exp);
    reg_addr_i = addr;
    #1;
    checkOutput(tag, reg_data_o, exp);
  endtask

  task automatic pulse0();
    int_i[0] = 1'b1;
    repeat (3) step();
    int_i[0] = 1'b0;
  endtask

  task automatic ack();
    int_ack_i = 1'b1;
    step();
    int_ack_i = 1'b0;
  endtask

  task automatic done();
    int_done_i = 1'b1;
    step();
    int_done_i = 1'b0;
  endtask

  logic seen_req;

  initial begin
    rst = 1'b0; int_i = '0; reg_addr_i = '0; reg_data_i = '0; reg_we_i = 1'b0;
    hold_flag_i = 1'b0; int_ack_i = 1'b0; int_done_i = 1'b0;
    #1;
    checkOutput("reset_req", {31'd0, int_req_o}, 32'd0);
    checkOutput("reset_id", {27'd0, int_id_o}, 32'd0);
    checkReg("reset_enable", 6'd0, 32'd0);
    checkReg("reset_pending", 6'd1, 32'd0);
    checkReg("reset_mode", 6'd2, 32'd0);
    checkReg("reset_thresh", 6'd3, 32'd0);
    checkReg("reset_prio0", 6'd4, 32'd0);
    checkReg("reset_prio7", 6'd11, 32'd0);
    checkReg("reset_status", 6'd36, 32'd0);
    step();
    rst = 1'b1;
    step();

    $display("[TB] unconfigured sources");
    int_i = 8'hFF;
    seen_req = 1'b0;
    repeat (20) begin
      step();
      seen_req |= int_req_o;
    end
    checkOutput("noprio_req", {31'd0, seen_req}, 32'd0);
    checkReg("level_pending", 6'd1, 32'h0000_00FF);
    checkReg("unmapped", 6'd40, 32'd0);
    int_i = 8'h00;
    repeat (4) step();

    $display("[TB] priority arbitration");
    applyStimulus(6'd6, 32'd3);
    applyStimulus(6'd9, 32'd6);
    applyStimulus(6'd0, 32'h24);
    checkReg("prio5_rb", 6'd9, 32'd6);
    int_i = 8'h24;
    repeat (3) step();
    checkOutput("lat_req_early", {31'd0, int_req_o}, 32'd0);
    step();
    checkOutput("lat_req", {31'd0, int_req_o}, 32'd1);
    checkOutput("prio_id5", {27'd0, int_id_o}, 32'd5);
    checkReg("status_req", 6'd36, 32'h15);
    ack();
    checkOutput("ack_drop", {31'd0, int_req_o}, 32'd0);
    checkReg("status_active", 6'd36, 32'h16);
    int_i = 8'h04;
    repeat (4) step();
    checkOutput("active_noreq", {31'd0, int_req_o}, 32'd0);
    done();
    checkOutput("done_idle", {31'd0, int_req_o}, 32'd0);
    step();
    checkOutput("rereq", {31'd0, int_req_o}, 32'd1);
    checkOutput("prio_id2", {27'd0, int_id_o}, 32'd2);
    ack();
    int_i = 8'h00;
    repeat (4) step();
    done();
    step();
    checkOutput("level_gone", {31'd0, int_req_o}, 32'd0);

    $display("[TB] tie and threshold");
    applyStimulus(6'd5, 32'd4);
    applyStimulus(6'd7, 32'd4);
    applyStimulus(6'd0, 32'h0A);
    applyStimulus(6'd3, 32'd4);
    int_i = 8'h0A;
    repeat (6) step();
    checkOutput("thresh_block", {31'd0, int_req_o}, 32'd0);
    checkReg("tie_pending", 6'd1, 32'h0A);
    applyStimulus(6'd3, 32'd3);
    checkOutput("thresh_next_cycle", {31'd0, int_req_o}, 32'd0);
    step();
    checkOutput("tie_req", {31'd0, int_req_o}, 32'd1);
    checkOutput("tie_id1", {27'd0, int_id_o}, 32'd1);
    ack();
    int_i = 8'h00;
    repeat (4) step();
    done();
    step();

    $display("[TB] edge mode");
    applyStimulus(6'd2, 32'h01);
    applyStimulus(6'd4, 32'd1);
    applyStimulus(6'd3, 32'd0);
    applyStimulus(6'd0, 32'h01);
    pulse0();
    checkReg("edge_pending", 6'd1, 32'h01);
    checkOutput("edge_req_early", {31'd0, int_req_o}, 32'd0);
    step();
    checkOutput("edge_req", {31'd0, int_req_o}, 32'd1);
    checkOutput("edge_id0", {27'd0, int_id_o}, 32'd0);
    ack();
    checkReg("ack_clears", 6'd1, 32'd0);
    repeat (4) step();
    done();
    seen_req = 1'b0;
    repeat (6) begin
      step();
      seen_req |= int_req_o;
    end
    checkOutput("edge_single_req", {31'd0, seen_req}, 32'd0);
    step();
    checkOutput("edge2_req", {31'd0, int_req_o}, 32'd0);
    pulse0();
    step();
    checkOutput("edge2_req_up", {31'd0, int_req_o}, 32'd1);
    ack();
    pulse0();
    checkReg("active_pulse_pending", 6'd1, 32'h01);
    checkOutput("active_pulse_noreq", {31'd0, int_req_o}, 32'd0);
    done();
    step();
    checkOutput("after_done_req", {31'd0, int_req_o}, 32'd1);
    ack();
    checkReg("ack2_clears", 6'd1, 32'd0);
    done();
    step();

    $display("[TB] W1C while idle");
    applyStimulus(6'd0, 32'h00);
    pulse0();
    step();
    checkReg("w1c_before", 6'd1, 32'h01);
    applyStimulus(6'd1, 32'h01);
    checkReg("w1c_after", 6'd1, 32'd0);
    applyStimulus(6'd0, 32'h01);
    repeat (3) step();
    checkOutput("w1c_noreq", {31'd0, int_req_o}, 32'd0);

    $display("[TB] hold");
    hold_flag_i = 1'b1;
    pulse0();
    repeat (3) step();
    checkOutput("hold_block", {31'd0, int_req_o}, 32'd0);
    hold_flag_i = 1'b0;
    step();
    checkOutput("hold_release", {31'd0, int_req_o}, 32'd1);
    hold_flag_i = 1'b1;
    repeat (3) step();
    checkOutput("hold_in_req", {31'd0, int_req_o}, 32'd1);
    ack();
    checkOutput("hold_ack", {31'd0, int_req_o}, 32'd0);
    hold_flag_i = 1'b0;
    done();

    $display("[TB] set/clear collision");
    applyStimulus(6'd0, 32'h00);
    int_i[0] = 1'b1;
    step();
    step();
    applyStimulus(6'd1, 32'h01);
    checkReg("set_wins", 6'd1, 32'h01);
    int_i[0] = 1'b0;
    repeat (3) step();
    applyStimulus(6'd1, 32'h01);
    checkReg("collision_cleanup", 6'd1, 32'd0);

    $display("[TB] reset mid-handshake");
    applyStimulus(6'd0, 32'h01);
    pulse0();
    step();
    ack();
    checkReg("pre_reset_status", 6'd36, 32'h02);
    rst = 1'b0;
    #1;
    checkOutput("rst_req", {31'd0, int_req_o}, 32'd0);
    checkOutput("rst_id", {27'd0, int_id_o}, 32'd0);
    checkReg("rst_status", 6'd36, 32'd0);
    checkReg("rst_enable", 6'd0, 32'd0);
    rst = 1'b1;
    step();

    $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/int_arbiter.md
# int_arbiter

Parametrised interrupt arbiter placed between the SoC interrupt lines and the tinyriscv core's interrupt input. It synchronises NUM_SRC asynchronous sources, latches level or edge events, selects the highest-priority enabled pending source above a threshold, and presents it to the core with a request/acknowledge/complete handshake. Unlike the fixed `INT_BUS` input of the core, the arbiter adds per-source enable, mode and priority, plus a threshold. These are configured over a word-addressed register port driven by the core's bus.

## Interface
- NUM_SRC, 8, number of interrupt sources (1..32)
- PRIO_W, 3, priority field width; priority 0 means never taken
- ID_W, 5, width of source index output (must satisfy 2^ID_W >= NUM_SRC)
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- int_i  in  NUM_SRC  raw interrupt lines, asynchronous to clk
- reg_addr_i  in  6  word index of register
- reg_data_i  in  32  write data
- reg_we_i  in  1  write strobe, one cycle per write
- reg_data_o  out  32  read data, combinational from reg_addr_i
- hold_flag_i  in  1  bus hold / jtag halt; blocks new requests
- int_req_o  out  1  interrupt request to core
- int_id_o  out  ID_W  index of requested/in-service source
- int_ack_i  in  1  core accepts request (taken on trap entry)
- int_done_i  in  1  core finished handler (mret)

## Operation
- Register map (word index):
  - 0 ENABLE[NUM_SRC-1:0]
  - 1 PENDING, read; write-1-to-clear for edge sources, ignored for level sources
  - 2 MODE, 1 = rising-edge, 0 = level-high
  - 3 THRESHOLD[PRIO_W-1:0]
  - 4+i PRIO[i][PRIO_W-1:0] for i < NUM_SRC
  - 36 STATUS: {int_id_o, state}, read-only
  - Unmapped indices read 0; writes to them are ignored; unused upper bits read 0.
- Sources:
  - Two-flop synchroniser per line, then an edge detector on the synchronised value.
  - Level source: PENDING[i] is a registered copy of the synchronised line.
  - Edge source: PENDING[i] is set on a rising edge. It is cleared by a W1C write or when the core acks that source.
  - If a set and a clear hit the same cycle, the set wins.
- Eligible source: ENABLE & PENDING and PRIO > THRESHOLD. The winner is the highest PRIO; ties go to the lowest index.
- FSM:
  - IDLE → REQ when any source is eligible and hold_flag_i = 0. The winner is latched into int_id_o.
  - REQ: int_req_o = 1 and int_id_o is held stable. No withdrawal: the request stays up even if the source drops or is disabled. REQ → ACTIVE on int_ack_i; an edge source's pending bit is cleared in that same cycle.
  - ACTIVE: int_req_o = 0 and int_id_o is held. No nesting or preemption. ACTIVE → IDLE on int_done_i.
  - int_done_i outside ACTIVE and int_ack_i outside REQ are ignored.
- hold_flag_i only gates the IDLE→REQ transition. It does not affect REQ or ACTIVE.
- Config writes are effective from the next cycle's arbitration. int_id_o is never re-evaluated while latched.

## Timing
- Reset state: all registers 0, FSM in IDLE, int_req_o = 0, int_id_o = 0, synchronisers 0. reg_data_o reflects the reset registers (0). Because PRIO = 0 after reset, nothing fires until software configures priorities.
- Latency: int_i high before edge k → PENDING set after edge k+2 → int_req_o high after edge k+3, when eligible, the FSM is IDLE and hold is low.
- int_ack_i sampled high at edge m → int_req_o low after edge m.
- int_done_i at edge n → IDLE after edge n. A new int_req_o can rise after edge n+1 at the earliest.
- A level source that is still high after done is re-requested. It is not lost or duplicated.
- Reset asserted mid-handshake returns to IDLE immediately (asynchronous). Pending state is lost.
- An edge pulse shorter than one clk period is not guaranteed to be captured. Pulses of two or more cycles are always captured.

## Test plan
- Reset check: outputs 0, all registers read 0. Then drive int_i = 8'hFF with no configuration → int_req_o stays 0 for 20 cycles.
- Priority arbitration:
  - Setup: PRIO[2] = 3, PRIO[5] = 6, ENABLE = 8'h24, level mode, THRESHOLD = 0.
  - Stimulus: assert int_i[2] and int_i[5] together.
  - Response: int_req_o after 4 edges with int_id_o = 5. Ack, then done with int_i[5] deasserted → next request has int_id_o = 2.
- Tie and threshold:
  - Setup: PRIO[1] = PRIO[3] = 4.
  - THRESHOLD = 4 → no request.
  - THRESHOLD = 3 → int_id_o = 1.
- Edge mode:
  - Setup: MODE[0] = 1, PRIO[0] = 1.
  - A 3-cycle pulse on int_i[0] → PENDING[0] = 1 → ack clears it, and exactly one request is issued.
  - A second pulse during ACTIVE → re-requested after done.
  - A W1C write of PENDING while idle clears it with no request.
- Hold:
  - Assert hold_flag_i with a source eligible → no int_req_o.
  - Release → int_req_o after 1 edge.
  - Assert hold during REQ → int_req_o remains 1 until ack.
- Simultaneous events and reset:
  - A W1C write in the same cycle as a new edge on that source → PENDING stays 1.
  - Drop rst during ACTIVE → int_req_o = 0, int_id_o = 0 immediately, and the FSM is in IDLE.
